pwm_bank: RTL and testbench
===========================

# pwm_bank

Parametrised multi-channel PWM generator that replaces the single-channel, fixed-period, 4-bit PWM controller in the slave datapath. Provides CHANNELS independent outputs sharing one programmable period counter. Each channel has a shadowed duty register and an output-polarity register. Shadowed values are written through a valid/ready port and take effect only at period boundaries, so no output glitches. A configurable minimum-duty offset covers loads that need a floor drive level.

## Interface
Parameters:
- CHANNELS, 4: number of PWM outputs; must be ≥ 2.
- WIDTH, 8: counter, period and duty width in bits.
- MIN_DUTY, 0: offset added to every non-zero duty value.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = run counter; 0 = hold outputs inactive.
- period  in  WIDTH  period value P; PWM period is P+1 cycles; sampled only at boundaries or while disabled.
- wr_valid  in  1  duty/polarity write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_channel  in  $clog2(CHANNELS)  target channel.
- wr_duty  in  WIDTH  new duty D.
- wr_invert  in  1  new polarity; 1 = active-low output.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  one-cycle pulse aligned with the first output cycle of each period.

## Operation
- Per channel: shadow {duty, invert} and active {duty, invert}. Common: counter and period_active, both WIDTH bits.
- Write: on wr_valid && wr_ready, shadow[wr_channel] <= {wr_duty, wr_invert}. If wr_channel ≥ CHANNELS, the write is accepted and dropped.
- Boundary while enabled: counter == period_active.
  - On a boundary: counter <= 0; period_active <= period; every active <= its shadow.
  - Otherwise: counter <= counter + 1.
- While enable = 0:
  - counter <= 0.
  - period_active <= period.
  - active <= shadow every cycle, so a re-enable starts with the newest values.
- Effective duty, computed WIDTH+1 bits wide with no overflow:
  - E = 0 if D == 0.
  - Otherwise E = min(D + MIN_DUTY, period_active + 1).
- Raw level = (counter < E). pwm_out[i] <= raw ^ invert_active[i] while enabled.
- When disabled, pwm_out[i] <= invert_active[i], i.e. the inactive level.
- period_start <= enable && counter == 0.
- wr_ready = ready_q && !(enable && counter == period_active).
  - ready_q resets to 0 and is 1 from the first cycle after reset is released.
  - Writes are therefore never accepted in the same cycle as a shadow→active transfer; the writer holds wr_valid.

## Timing
- Reset (reset_n = 0 at an edge) sets: counter, period_active, all duty and invert registers, pwm_out, period_start and ready_q to 0. wr_ready is 0 during reset and for the first cycle after.
- Reset mid-period takes effect at the next edge; outputs are 0 one edge later at most.
- Output latency: one cycle from counter value to pwm_out.
- Write-to-effect: a write accepted in period k appears at the first output cycle of period k+1. The worst case is P+2 cycles.
- A write accepted in the last cycle before the boundary-ready drop still transfers at that boundary.
- Duty boundary cases:
  - D = 0: output constantly inactive.
  - E ≥ P+1: output constantly active.
  - P = 0: every cycle is a boundary, so wr_ready is 0 while enabled. Writes are possible only while disabled.
- Counter wrap: the counter never exceeds period_active. A period decrease takes effect at the boundary, never mid-period.
- Simultaneous enable fall and boundary: the disable rules win.

## Structure
- Package pwm_bank_pkg: a typedef for the per-channel config struct {duty, invert}, plus a function computing effective duty with WIDTH+1-bit saturation.
- Sub-module pwm_bank_channel: shadow/active registers, effective-duty compare, polarity and output flop. Instantiated CHANNELS times in a generate loop.
- The top level holds the counter, period_active, ready logic and write decode.

## Test plan
- Reset, then enable with P=9 and ch0 D=3: pwm_out[0] is high exactly 3 of every 10 cycles; period_start pulses every 10 cycles; all other channels stay 0.
- Write ch1 D=7 in mid-period while ch1 is at D=2: the current period keeps a 2-cycle high; the next period, starting on the period_start pulse, has a 7-cycle high. wr_ready drops exactly on boundary cycles.
- Boundary cases with P=9: D=0 gives constant 0; D=10 and D=255 give constant 1; wr_invert=1 with D=3 gives 3 low and 7 high.
- Build with MIN_DUTY=4, P=15: D=1 gives 5 high; D=0 gives 0 high; D=14 saturates to 16 high.
- Change period from 9 to 4 mid-period: the current period completes 10 cycles and the next is 5 cycles. Then drop enable: outputs go to their inactive levels and the counter resets. Re-enable: first period_start one cycle after the counter restarts.
- Assert reset_n=0 mid-period with an active write: all outputs are 0 next edge, wr_ready is 0, and the previous shadows are cleared, so duty reads 0 after reset.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared types and helpers for the multi-channel PWM bank.
// MAX_WIDTH bounds the WIDTH parameter of pwm_bank; narrower builds zero-extend into these fields.
package pwm_bank_pkg;

  localparam int MAX_WIDTH = 16;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] duty;
    logic                 invert;
  } chan_cfg_t;

  // Zero duty is always off; otherwise the offset duty saturates at one full period.
  function automatic logic [MAX_WIDTH:0] effective_duty(
    input logic [MAX_WIDTH-1:0] duty,
    input logic [MAX_WIDTH-1:0] period,
    input logic [MAX_WIDTH-1:0] min_duty
  );
    logic [MAX_WIDTH:0] sum;
    logic [MAX_WIDTH:0] limit;
    sum   = {1'b0, duty} + {1'b0, min_duty};
    limit = {1'b0, period} + {{MAX_WIDTH{1'b0}}, 1'b1};
    if (duty == '0) begin
      effective_duty = '0;
    end else if (sum > limit) begin
      effective_duty = limit;
    end else begin
      effective_duty = sum;
    end
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: shadow and active config registers, duty compare and registered output.
module pwm_bank_channel
  import pwm_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MIN_DUTY = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             transfer,
  input  logic             wr_en,
  input  chan_cfg_t        wr_cfg,
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] period_active,
  output logic             pwm_out
);

  chan_cfg_t          shadow_q, shadow_d;
  chan_cfg_t          active_q, active_d;
  logic               pwm_q, pwm_d;
  logic [MAX_WIDTH:0] eff_duty;
  logic               raw;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) begin
      shadow_d = wr_cfg;
    end
    // Transfer uses the pre-write shadow so a write never bypasses the boundary.
    if (transfer) begin
      active_d = shadow_q;
    end
    eff_duty = effective_duty(active_q.duty, MAX_WIDTH'(period_active), MAX_WIDTH'(MIN_DUTY));
    raw      = ((MAX_WIDTH+1)'(counter) < eff_duty);
    pwm_d    = enable ? (raw ^ active_q.invert) : active_q.invert;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: shared period counter, write decode and boundary-aware ready.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int MIN_DUTY = 0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [WIDTH-1:0]            period,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [$clog2(CHANNELS)-1:0] wr_channel,
  input  logic [WIDTH-1:0]            wr_duty,
  input  logic                        wr_invert,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic                        period_start
);

  localparam int CH_W = $clog2(CHANNELS);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] period_active_q, period_active_d;
  logic             period_start_q, period_start_d;
  logic             ready_q, ready_d;
  logic             boundary;
  logic             transfer;
  logic             wr_accept;
  chan_cfg_t        wr_cfg;

  always_comb begin
    boundary        = enable && (counter_q == period_active_q);
    transfer        = !enable || boundary;
    counter_d       = counter_q + WIDTH'(1);
    period_active_d = period_active_q;
    if (transfer) begin
      counter_d       = '0;
      period_active_d = period;
    end
    period_start_d = enable && (counter_q == '0);
    ready_d        = 1'b1;
    wr_ready       = ready_q && !boundary;
    wr_accept      = wr_valid && wr_ready;
    wr_cfg         = '{duty: MAX_WIDTH'(wr_duty), invert: wr_invert};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      counter_q       <= '0;
      period_active_q <= '0;
      period_start_q  <= 1'b0;
      ready_q         <= 1'b0;
    end else begin
      counter_q       <= counter_d;
      period_active_q <= period_active_d;
      period_start_q  <= period_start_d;
      ready_q         <= ready_d;
    end
  end

  assign period_start = period_start_q;

  // Channel indices without a matching instance simply never decode, dropping the write.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_bank_channel #(
      .WIDTH    (WIDTH),
      .MIN_DUTY (MIN_DUTY)
    ) u_channel (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable        (enable),
      .transfer      (transfer),
      .wr_en         (wr_accept && (wr_channel == CH_W'(i))),
      .wr_cfg        (wr_cfg),
      .counter       (counter_q),
      .period_active (period_active_q),
      .pwm_out       (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: vector table of single-channel duty cases plus multi-cycle sequences.
module tb_pwm_bank;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] period;
  logic       wr_valid;
  logic [1:0] wr_channel;
  logic [7:0] wr_duty;
  logic       wr_invert;
  logic       wr_ready, wr_ready_m;
  logic [3:0] pwm_out, pwm_out_m;
  logic       period_start, period_start_m;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_duty [4];
  logic       m_inv  [4];

  typedef struct {
    logic [7:0] duty;
    logic       invert;
    logic [7:0] per;
    bit         use_min;
    int         exp_high;
  } vec_t;

  vec_t vecs [11];

  always #5 clock = ~clock;

  pwm_bank #(.CHANNELS(4), .WIDTH(8), .MIN_DUTY(0)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .period(period),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_channel(wr_channel),
    .wr_duty(wr_duty), .wr_invert(wr_invert), .pwm_out(pwm_out),
    .period_start(period_start)
  );

  pwm_bank #(.CHANNELS(4), .WIDTH(8), .MIN_DUTY(4)) dut_m (
    .clock(clock), .reset_n(reset_n), .enable(enable), .period(period),
    .wr_valid(wr_valid), .wr_ready(wr_ready_m), .wr_channel(wr_channel),
    .wr_duty(wr_duty), .wr_invert(wr_invert), .pwm_out(pwm_out_m),
    .period_start(period_start_m)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_period_start(input string name);
    int n = 0;
    while (period_start !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (period_start !== 1'b1) checkOutput({name, " period_start timeout"}, 0, 1);
  endtask

  task automatic do_write(input int ch, input logic [7:0] d, input logic inv);
    int n = 0;
    wr_valid   = 1'b1;
    wr_channel = ch[1:0];
    wr_duty    = d;
    wr_invert  = inv;
    while (!wr_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!wr_ready) checkOutput("write handshake timeout", 0, 1);
    @(negedge clock);
    wr_valid   = 1'b0;
    m_duty[ch] = d;
    m_inv[ch]  = inv;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int high   = 0;
    int extra  = 0;
    int others = 0;
    enable = 1'b0;
    period = v.per;
    do_write(0, v.duty, v.invert);
    repeat (2) @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    wait_period_start($sformatf("vec%0d", idx));
    for (int c = 0; c <= int'(v.per); c++) begin
      high   += v.use_min ? int'(pwm_out_m[0]) : int'(pwm_out[0]);
      others += int'(pwm_out[2]) + int'(pwm_out[3]);
      if (c > 0 && period_start) extra++;
      @(negedge clock);
    end
    checkOutput($sformatf("vec%0d high cycles", idx), high, v.exp_high);
    checkOutput($sformatf("vec%0d early period_start", idx), extra, 0);
    checkOutput($sformatf("vec%0d period_start after P+1", idx), int'(period_start), 1);
    checkOutput($sformatf("vec%0d idle channels", idx), others, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int high;
    int ps;
    logic [3:0] exp_mask;

    for (int i = 0; i < 4; i++) begin
      m_duty[i] = '0;
      m_inv[i]  = 1'b0;
    end

    vecs[0]  = '{8'd3,   1'b0, 8'd9,  1'b0, 3};
    vecs[1]  = '{8'd0,   1'b0, 8'd9,  1'b0, 0};
    vecs[2]  = '{8'd10,  1'b0, 8'd9,  1'b0, 10};
    vecs[3]  = '{8'd255, 1'b0, 8'd9,  1'b0, 10};
    vecs[4]  = '{8'd3,   1'b1, 8'd9,  1'b0, 7};
    vecs[5]  = '{8'd9,   1'b0, 8'd9,  1'b0, 9};
    vecs[6]  = '{8'd1,   1'b0, 8'd15, 1'b1, 5};
    vecs[7]  = '{8'd0,   1'b0, 8'd15, 1'b1, 0};
    vecs[8]  = '{8'd14,  1'b0, 8'd15, 1'b1, 16};
    vecs[9]  = '{8'd11,  1'b0, 8'd15, 1'b1, 15};
    vecs[10] = '{8'd1,   1'b0, 8'd0,  1'b0, 1};

    reset_n = 1'b0; enable = 1'b0; period = 8'd9;
    wr_valid = 1'b0; wr_channel = '0; wr_duty = '0; wr_invert = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset pwm_out", int'(pwm_out), 0);
    checkOutput("reset period_start", int'(period_start), 0);
    checkOutput("reset wr_ready", int'(wr_ready), 0);
    reset_n = 1'b1;
    checkOutput("wr_ready first cycle after reset", int'(wr_ready), 0);
    @(negedge clock);
    checkOutput("wr_ready after reset", int'(wr_ready), 1);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);
    checkOutput("P0 wr_ready while enabled", int'(wr_ready), 0);

    // Mid-period duty change on ch1 takes effect only from the next period.
    enable = 1'b0; period = 8'd9;
    do_write(1, 8'd2, 1'b0);
    repeat (2) @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    wait_period_start("seq1");
    high = 0;
    for (int c = 0; c < 10; c++) begin
      high += int'(pwm_out[1]);
      checkOutput($sformatf("seq1 wr_ready c%0d", c), int'(wr_ready), (c == 8) ? 0 : 1);
      if (c == 4) begin
        wr_valid = 1'b1; wr_channel = 2'd1; wr_duty = 8'd7; wr_invert = 1'b0;
      end
      if (c == 5) wr_valid = 1'b0;
      @(negedge clock);
    end
    m_duty[1] = 8'd7;
    checkOutput("seq1 old period high", high, 2);
    checkOutput("seq1 period_start", int'(period_start), 1);
    high = 0;
    for (int c = 0; c < 10; c++) begin
      high += int'(pwm_out[1]);
      @(negedge clock);
    end
    checkOutput("seq1 new period high", high, 7);
    checkOutput("seq1 second period_start", int'(period_start), 1);

    // Period decrease mid-period completes the current 10-cycle period first.
    ps = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) ps += int'(period_start);
      if (c == 3) period = 8'd4;
      @(negedge clock);
    end
    checkOutput("seq2 no early period_start", ps, 0);
    checkOutput("seq2 period_start at 10", int'(period_start), 1);
    ps = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) ps += int'(period_start);
      @(negedge clock);
    end
    checkOutput("seq2 short period no early start", ps, 0);
    checkOutput("seq2 period_start at 5", int'(period_start), 1);

    do_write(3, 8'd5, 1'b1);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    exp_mask = {m_inv[3], m_inv[2], m_inv[1], m_inv[0]};
    checkOutput("disable inactive levels", int'(pwm_out), int'(exp_mask));
    checkOutput("disable period_start", int'(period_start), 0);
    enable = 1'b1;
    @(negedge clock);
    checkOutput("re-enable period_start", int'(period_start), 1);
    ps = 0; high = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) ps += int'(period_start);
      high += int'(pwm_out[3]);
      @(negedge clock);
    end
    checkOutput("re-enable no early start", ps, 0);
    checkOutput("re-enable period_start at 5", int'(period_start), 1);
    checkOutput("ch3 inverted full duty high", high, 0);

    // Reset mid-period with a write in flight clears every register.
    repeat (2) @(negedge clock);
    wr_valid = 1'b1; wr_channel = 2'd0; wr_duty = 8'd5; wr_invert = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    checkOutput("mid reset pwm_out", int'(pwm_out), 0);
    checkOutput("mid reset period_start", int'(period_start), 0);
    checkOutput("mid reset wr_ready", int'(wr_ready), 0);
    wr_valid = 1'b0; enable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_duty[i] = '0;
      m_inv[i]  = 1'b0;
    end
    repeat (2) @(negedge clock);
    period = 8'd9; enable = 1'b1;
    @(negedge clock);
    wait_period_start("post reset");
    high = 0;
    for (int c = 0; c < 10; c++) begin
      high += $countones(pwm_out) + $countones(pwm_out_m);
      @(negedge clock);
    end
    checkOutput("post reset all outputs low", high, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
